// File: rtl/demux_pkg.sv
// Shared definitions for the 1:4 stream demux: lane index type, lane
// constants and the inverted sel-to-lane decode.
package demux_pkg;

  typedef logic [1:0] lane_t;

  localparam lane_t LANE0 = 2'd0;
  localparam lane_t LANE1 = 2'd1;
  localparam lane_t LANE2 = 2'd2;
  localparam lane_t LANE3 = 2'd3;

  // Select encoding is inverted: 2'b11 addresses lane 0, 2'b00 lane 3.
  function automatic lane_t sel_to_lane(input logic [1:0] sel);
    return lane_t'(~sel);
  endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One-entry registered output lane with valid/ready handshake.
// Optional saturating accept counter is built when DEMUX_CNT_EN is defined.
module demux_lane_reg
  import demux_pkg::*;
#(
  parameter int W = 2
`ifdef DEMUX_CNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [W-1:0]     din,
  input  logic             ready,
  output logic [W-1:0]     data,
  output logic             valid
`ifdef DEMUX_CNT_EN
  , output logic [CNT_W-1:0] cnt
`endif
);

  logic [W-1:0] data_reg;
  logic         valid_reg;

  // A load wins over a drain, so a simultaneous drain+load keeps valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      data_reg  <= din;
      valid_reg <= 1'b1;
    end else if (valid_reg && ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign data  = data_reg;
  assign valid = valid_reg;

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;
`endif

endmodule

// File: rtl/demux1_4_stream.sv
// 1:4 stream demultiplexer with per-lane one-entry registered outputs.
// Per-lane transfer counters are built when DEMUX_CNT_EN is defined.
module demux1_4_stream
  import demux_pkg::*;
#(
  parameter int W = 2
`ifdef DEMUX_CNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     din,
  input  logic [1:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     d0,
  output logic [W-1:0]     d1,
  output logic [W-1:0]     d2,
  output logic [W-1:0]     d3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
`ifdef DEMUX_CNT_EN
  , output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
`endif
);

  lane_t        lane;
  logic         accept;
  logic [W-1:0] lane_data [4];
`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] lane_cnt [4];
`endif

  // Readiness depends only on the addressed lane, never on in_valid.
  assign lane     = sel_to_lane(sel);
  assign in_ready = !out_valid[lane] || out_ready[lane];
  assign accept   = in_valid && in_ready;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      demux_lane_reg #(
        .W     (W)
`ifdef DEMUX_CNT_EN
        , .CNT_W (CNT_W)
`endif
      ) u_lane (
        .clk   (clk),
        .rst   (rst),
        .load  (accept && (lane == lane_t'(gi))),
        .din   (din),
        .ready (out_ready[gi]),
        .data  (lane_data[gi]),
        .valid (out_valid[gi])
`ifdef DEMUX_CNT_EN
        , .cnt (lane_cnt[gi])
`endif
      );
    end
  endgenerate

  assign d0 = lane_data[LANE0];
  assign d1 = lane_data[LANE1];
  assign d2 = lane_data[LANE2];
  assign d3 = lane_data[LANE3];

`ifdef DEMUX_CNT_EN
  assign cnt0 = lane_cnt[LANE0];
  assign cnt1 = lane_cnt[LANE1];
  assign cnt2 = lane_cnt[LANE2];
  assign cnt3 = lane_cnt[LANE3];
`endif

endmodule

// File: doc/demux1_4_stream.md
# demux1_4_stream

One-to-four stream demultiplexer: the distribution side of the 4:1 select path, routing one input stream to one of four output lanes. It uses the same inverted select encoding as the select path: sel 2'b11 selects lane 0 and 2'b00 selects lane 3. Each lane has a one-entry registered output with valid/ready flow control, so a stalled lane never blocks traffic to the other lanes. The block sits between a single producer and four independent consumers.

## Interface
- W, default 2: data width of the input and of each lane.
- CNT_W, default 8: width of the per-lane transfer counters (present only with DEMUX_CNT_EN).
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  W  input data.
- sel  input  2  destination lane: 11→lane0, 10→lane1, 01→lane2, 00→lane3.
- in_valid  input  1  din/sel valid.
- in_ready  output  1  block can accept this cycle.
- d0, d1, d2, d3  output  W each  lane data.
- out_valid  output  4  per-lane valid; bit i belongs to lane i.
- out_ready  input  4  per-lane consumer ready.
- cnt0..cnt3  output  CNT_W each  per-lane accepted-transfer count (only with DEMUX_CNT_EN).

## Operation
- Lane decode: lane index = ~sel; sel 11→0, 10→1, 01→2, 00→3.
- Each lane has a register holding data and a valid bit.
- in_ready = !out_valid[L] | out_ready[L], where L is the lane decoded from the current sel. It is combinational from sel, out_valid and out_ready, and does not depend on in_valid.
- Accept condition: in_valid & in_ready. On accept, lane L loads din and sets its valid bit.
- Drain: out_valid[i] & out_ready[i] clears lane i's valid bit, unless the same cycle also accepts new data into lane i.
- Simultaneous drain and accept on the same lane: the register reloads and valid stays 1. This gives full throughput of one word per cycle per lane.
- Non-selected lanes drain independently; several lanes can drain in the same cycle.
- out_valid must not drop and d_i must not change while a lane is valid and not ready (AXI-style stability).
- sel and din are sampled only on accept. While in_valid is low their values are don't-care.
- Lane data is not cleared on drain; d_i holds the last value loaded.

## Timing
- Latency: a word accepted at edge N appears on d_L with out_valid[L]=1 immediately after edge N.
- Throughput: one accept per cycle when the target lane is empty or draining that cycle.
- Reset (rst=1 at an edge): out_valid=4'b0000, d0..d3=0, counters=0. in_ready is then 1 for any sel.
- Reset mid-operation discards held words; no output handshake completes in a cycle with rst high.
- Back-to-back words to a stalled lane: the first is held, in_ready=0 for that sel, the producer stalls. Switching sel to an empty lane restores in_ready=1 the same cycle.

## Configuration
- DEMUX_CNT_EN defined: four CNT_W-bit counters. cnt_i increments on every accept into lane i and saturates at all-ones (no wrap). They reset to 0.
- DEMUX_CNT_EN undefined: the counters and the cnt0..cnt3 ports are absent. Datapath behaviour is identical.

## Structure
- Shared package demux_pkg:
  - lane index typedef (2 bits);
  - sel-to-lane decode function;
  - lane constants LANE0..LANE3 = 0..3.
- One sub-module, demux_lane_reg, instantiated four times. It holds a W-bit one-entry register with load, drain and valid, plus the optional saturating counter.
- The top level contains only decode, in_ready generation and the lane instances.

## Test plan
- Reset then idle:
  - after rst, out_valid=0000, d0..d3=0, in_ready=1 for all four sel values.
- Routing map:
  - stimulus: send din=01,10,11,00 with sel=11,10,01,00 in consecutive cycles, all out_ready=1111;
  - expected: d0=01, d1=10, d2=11, d3=00, each valid for exactly one cycle, one cycle after its accept.
- Backpressure isolation:
  - stimulus: out_ready=1110; send din=11 with sel=11, then din=10 with sel=11;
  - expected: d0=11 held with out_valid[0]=1, in_ready=0 for sel=11; switching sel=10 gives in_ready=1 and lane1 receives data.
- Simultaneous drain and accept:
  - stimulus: lane2 full, out_ready[2]=1, in_valid with sel=01 and din=10;
  - expected: out_valid[2] stays 1, d2 becomes 10, no bubble.
- Reset mid-stall:
  - stimulus: lanes 0 and 3 valid and stalled, assert rst for one cycle;
  - expected: out_valid=0000 next cycle, held words lost, accepts resume normally.
- Counter saturation (DEMUX_CNT_EN, CNT_W=8):
  - stimulus: 300 accepts into lane1;
  - expected: cnt1=255, other counters 0.
